// File: rtl/i2c_scl_generator_if.sv
// i2c_scl_generator_if
// Bundles the bit-engine side configuration, the open-drain pad pair and the
// phase/status outputs of the SCL generator. The generator uses the master
// modport; the bit engine (or a test bench) uses the slave modport.
interface i2c_scl_generator_if #(
  parameter int CNT_WIDTH = 8
);

  logic                 enable;
  logic [CNT_WIDTH-1:0] low_count;
  logic [CNT_WIDTH-1:0] high_count;
  logic                 scl_i;
  logic                 scl_pull_low;
  logic                 fall_tick;
  logic                 mid_low_tick;
  logic                 rise_tick;
  logic                 mid_high_tick;
  logic                 stretching;
  logic                 busy;
  logic                 stretch_timeout;

  modport master (
    input  enable,
    input  low_count,
    input  high_count,
    input  scl_i,
    output scl_pull_low,
    output fall_tick,
    output mid_low_tick,
    output rise_tick,
    output mid_high_tick,
    output stretching,
    output busy,
    output stretch_timeout
  );

  modport slave (
    output enable,
    output low_count,
    output high_count,
    output scl_i,
    input  scl_pull_low,
    input  fall_tick,
    input  mid_low_tick,
    input  rise_tick,
    input  mid_high_tick,
    input  stretching,
    input  busy,
    input  stretch_timeout
  );

endinterface

// File: rtl/i2c_scl_generator.sv
// i2c_scl_generator
// I2C SCL master clock generator: programmable LOW/HIGH lengths, clock-stretch
// wait, multi-master synchronisation and four phase ticks for the bit engine.
// All outputs are registered.
// Optional feature: define I2C_SCL_TIMEOUT_EN to abort a HIGH_WAIT that lasts
// STRETCH_LIMIT cycles (sticky stretch_timeout, cleared by enable=0).
module i2c_scl_generator #(
  parameter int CNT_WIDTH     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int MULTI_MASTER  = 1,
  parameter int STRETCH_LIMIT = 4095
) (
  input  logic                   clk_in,
  input  logic                   reset_n,
  i2c_scl_generator_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    HIGH_WAIT = 2'd2,
    HIGH      = 2'd3
  } state_t;

  // The state register is the final resolving stage of the pad synchroniser,
  // so SYNC_STAGES-1 dedicated flops give an unstretched HIGH_WAIT dwell of
  // exactly SYNC_STAGES cycles.
  localparam int CHAIN = (SYNC_STAGES > 1) ? SYNC_STAGES - 1 : 1;

  localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] TWO      = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] SYNC_CNT = CNT_WIDTH'(SYNC_STAGES);

  if (SYNC_STAGES < 2 || STRETCH_LIMIT < 1) begin : g_param_check
    $error("i2c_scl_generator: SYNC_STAGES must be >= 2 and STRETCH_LIMIT >= 1");
  end

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic [CNT_WIDTH-1:0] lo_q;
  logic [CNT_WIDTH-1:0] hi_q;
  logic [CNT_WIDTH-1:0] lo_eff;
  logic [CNT_WIDTH-1:0] hi_eff;
  logic [CHAIN-1:0]     sync_q;
  logic                 scl_s;
  logic                 pull_low_q;
  logic                 fall_q;
  logic                 mid_low_q;
  logic                 rise_q;
  logic                 mid_high_q;
  logic                 stretching_q;
  logic                 busy_q;
  logic                 can_start;
  logic                 stretch_expired;

  assign cnt_inc = cnt + ONE;
  assign lo_eff  = (bus.low_count  < TWO) ? TWO : bus.low_count;
  assign hi_eff  = (bus.high_count < TWO) ? TWO : bus.high_count;
  assign scl_s   = sync_q[CHAIN-1];

  // Bring the asynchronous pad level into clk_in; flops reset high (bus idle).
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
    end else begin
      sync_q[0] <= bus.scl_i;
      for (int i = 1; i < CHAIN; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

`ifdef I2C_SCL_TIMEOUT_EN
  localparam int SW = $clog2(STRETCH_LIMIT + 1);

  logic [SW-1:0] stretch_cnt;
  logic          timeout_q;

  // Count consecutive HIGH_WAIT cycles, saturating; cleared outside HIGH_WAIT.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      stretch_cnt <= '0;
    end else if (state != HIGH_WAIT) begin
      stretch_cnt <= '0;
    end else if (stretch_cnt != SW'(STRETCH_LIMIT)) begin
      stretch_cnt <= stretch_cnt + SW'(1);
    end
  end

  assign stretch_expired = (state == HIGH_WAIT) && !scl_s &&
                           (stretch_cnt == SW'(STRETCH_LIMIT - 1));

  // Sticky timeout flag; only dropping enable clears it and re-arms start.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else if (stretch_expired) begin
      timeout_q <= 1'b1;
    end else if (!bus.enable) begin
      timeout_q <= 1'b0;
    end
  end

  assign can_start           = !timeout_q;
  assign bus.stretch_timeout = timeout_q;
`else
  assign stretch_expired     = 1'b0;
  assign can_start           = 1'b1;
  assign bus.stretch_timeout = 1'b0;
`endif

  // SCL phase sequencer with registered pad control, ticks and status.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      pull_low_q   <= 1'b0;
      fall_q       <= 1'b0;
      mid_low_q    <= 1'b0;
      rise_q       <= 1'b0;
      mid_high_q   <= 1'b0;
      stretching_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      fall_q     <= 1'b0;
      mid_low_q  <= 1'b0;
      rise_q     <= 1'b0;
      mid_high_q <= 1'b0;
      case (state)
        IDLE: begin
          pull_low_q   <= 1'b0;
          stretching_q <= 1'b0;
          if (bus.enable && can_start) begin
            state      <= LOW;
            cnt        <= '0;
            lo_q       <= lo_eff;
            hi_q       <= hi_eff;
            pull_low_q <= 1'b1;
            fall_q     <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOW: begin
          if (cnt == lo_q - ONE) begin
            state      <= HIGH_WAIT;
            cnt        <= '0;
            pull_low_q <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == (lo_q >> 1)) begin
              mid_low_q <= 1'b1;
            end
          end
        end
        HIGH_WAIT: begin
          if (scl_s) begin
            state        <= HIGH;
            cnt          <= '0;
            rise_q       <= 1'b1;
            stretching_q <= 1'b0;
          end else if (stretch_expired) begin
            state        <= IDLE;
            cnt          <= '0;
            stretching_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            if (cnt != SYNC_CNT) begin
              cnt <= cnt_inc;
            end
            if (cnt_inc >= SYNC_CNT) begin
              stretching_q <= 1'b1;
            end
          end
        end
        HIGH: begin
          if ((MULTI_MASTER != 0 && !scl_s) ||
              (cnt == hi_q - ONE && bus.enable)) begin
            state      <= LOW;
            cnt        <= '0;
            lo_q       <= lo_eff;
            hi_q       <= hi_eff;
            pull_low_q <= 1'b1;
            fall_q     <= 1'b1;
          end else if (cnt == hi_q - ONE) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == (hi_q >> 1)) begin
              mid_high_q <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.scl_pull_low  = pull_low_q;
  assign bus.fall_tick     = fall_q;
  assign bus.mid_low_tick  = mid_low_q;
  assign bus.rise_tick     = rise_q;
  assign bus.mid_high_tick = mid_high_q;
  assign bus.stretching    = stretching_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_i2c_scl_generator.sv
// tb_i2c_scl_generator
// Scoreboard bench: each scenario pushes the ticks it expects (kind, cycle)
// into a queue; an independent negedge monitor pops and compares every tick
// the generator emits. Level checks are made directly by the stimulus.
module tb_i2c_scl_generator;

  localparam int LIMIT = 16;
`ifdef I2C_SCL_TIMEOUT_EN
  localparam int HOLD = 10;
`else
  localparam int HOLD = 20;
`endif

  typedef struct {
    int kind;
    int at;
  } tick_t;

  logic  clk_in     = 1'b0;
  logic  reset_n    = 1'b0;
  logic  slave_hold = 1'b0;
  logic  other_pull = 1'b0;
  int    cyc        = 0;
  int    checks     = 0;
  int    failures   = 0;
  tick_t exp_q[$];

  i2c_scl_generator_if #(.CNT_WIDTH(8)) bus ();

  i2c_scl_generator #(
    .CNT_WIDTH    (8),
    .SYNC_STAGES  (2),
    .MULTI_MASTER (1),
    .STRETCH_LIMIT(LIMIT)
  ) dut (
    .clk_in (clk_in),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Wired-AND pad: our driver, a stretching slave and a second master.
  assign bus.scl_i = !bus.scl_pull_low && !slave_hold && !other_pull;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic string kind_str(int k);
    case (k)
      0:       return "fall";
      1:       return "mid_low";
      2:       return "rise";
      default: return "mid_high";
    endcase
  endfunction

  task automatic check_output(string name, logic actual, logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, actual, expected);
    end
  endtask

  task automatic check_count(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic expect_tick(int kind, int at);
    tick_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic expect_period(int base, int lo, int hi);
    expect_tick(0, base);
    expect_tick(1, base + lo / 2);
    expect_tick(2, base + lo + 2);
    expect_tick(3, base + lo + 2 + hi / 2);
  endtask

  task automatic wait_cycle(int t);
    do begin
      @(posedge clk_in);
      #1;
    end while (cyc < t);
  endtask

  task automatic wait_neg(int t);
    wait_cycle(t);
    @(negedge clk_in);
  endtask

  task automatic apply_stimulus(int lo, int hi, logic en);
    bus.low_count  = 8'(lo);
    bus.high_count = 8'(hi);
    bus.enable     = en;
  endtask

  // Monitor: every emitted tick must match the head of the expectation queue.
  always @(negedge clk_in) begin : monitor
    logic [3:0] t;
    tick_t      e;
    t = {bus.mid_high_tick, bus.rise_tick, bus.mid_low_tick, bus.fall_tick};
    if ($countones(t) > 1) begin
      checks++;
      failures++;
      $display("[TB] FAIL one_tick cycle %0d: got ticks %b expected at most one", cyc, t);
    end
    for (int k = 0; k < 4; k++) begin
      if (t[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL tick cycle %0d: got %s expected none", cyc, kind_str(k));
        end else begin
          e = exp_q.pop_front();
          if (e.kind != k || e.at != cyc) begin
            failures++;
            $display("[TB] FAIL tick: got %s at %0d expected %s at %0d",
                     kind_str(k), cyc, kind_str(e.kind), e.at);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int f;
    int n;
    apply_stimulus(4, 4, 1'b0);

    // Reset state.
    wait_neg(2);
    check_output("reset_pull_low", bus.scl_pull_low, 1'b0);
    check_output("reset_busy", bus.busy, 1'b0);
    check_output("reset_fall", bus.fall_tick, 1'b0);
    check_output("reset_rise", bus.rise_tick, 1'b0);
    check_output("reset_stretching", bus.stretching, 1'b0);
    check_output("reset_timeout", bus.stretch_timeout, 1'b0);
    wait_cycle(3);
    reset_n = 1'b1;

    // Free-running 4/4: 10-cycle period, then enable drop in mid-LOW.
    wait_cycle(6);
    $display("[TB] normal run lo=4 hi=4");
    f = cyc + 1;
    apply_stimulus(4, 4, 1'b1);
    for (int p = 0; p < 3; p++) expect_period(f + 10 * p, 4, 4);
    wait_neg(f + 1);
    check_output("normal_busy", bus.busy, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      wait_neg(f + 10 + i);
      if (bus.scl_pull_low) n++;
    end
    check_count("normal_low_cycles", n, 4);
    wait_cycle(f + 21);
    bus.enable = 1'b0;
    wait_neg(f + 29);
    check_output("drop_last_high_busy", bus.busy, 1'b1);
    wait_neg(f + 30);
    check_output("drop_idle_busy", bus.busy, 1'b0);
    check_output("drop_idle_pull", bus.scl_pull_low, 1'b0);
    wait_neg(f + 35);
    check_output("drop_still_idle", bus.busy, 1'b0);

    // Clamped counts 0/1 behave as 2/2: 6-cycle period.
    wait_cycle(cyc + 2);
    $display("[TB] clamp run lo=0 hi=1");
    f = cyc + 1;
    apply_stimulus(0, 1, 1'b1);
    expect_period(f, 2, 2);
    expect_period(f + 6, 2, 2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      wait_neg(f + i);
      if (bus.scl_pull_low) n++;
    end
    check_count("clamp_low_cycles", n, 2);
    wait_cycle(f + 7);
    bus.enable = 1'b0;
    wait_neg(f + 12);
    check_output("clamp_idle_busy", bus.busy, 1'b0);

    // Slave stretch: scl_i held low HOLD cycles after our release.
    wait_cycle(cyc + 2);
    $display("[TB] stretch run hold=%0d", HOLD);
    f = cyc + 1;
    slave_hold = 1'b1;
    apply_stimulus(4, 4, 1'b1);
    expect_tick(0, f);
    expect_tick(1, f + 2);
    expect_tick(2, f + HOLD + 6);
    expect_tick(3, f + HOLD + 8);
    wait_cycle(f + 2);
    bus.enable = 1'b0;
    wait_neg(f + 5);
    check_output("stretch_dwell_not_yet", bus.stretching, 1'b0);
    wait_neg(f + 6);
    check_output("stretch_active", bus.stretching, 1'b1);
    check_output("stretch_released", bus.scl_pull_low, 1'b0);
    wait_cycle(f + 4 + HOLD);
    slave_hold = 1'b0;
    wait_neg(f + 5 + HOLD);
    check_output("stretch_last", bus.stretching, 1'b1);
    wait_neg(f + 6 + HOLD);
    check_output("stretch_end", bus.stretching, 1'b0);
    wait_neg(f + HOLD + 12);
    check_output("stretch_idle_busy", bus.busy, 1'b0);

    // Second master pulls SCL low early in HIGH: LOW restarts, no mid_high.
    wait_cycle(cyc + 2);
    $display("[TB] multi-master run");
    f = cyc + 1;
    apply_stimulus(4, 4, 1'b1);
    expect_tick(0, f);
    expect_tick(1, f + 2);
    expect_tick(2, f + 6);
    expect_period(f + 8, 4, 4);
    wait_cycle(f + 6);
    other_pull = 1'b1;
    wait_neg(f + 8);
    check_output("mm_restart_pull", bus.scl_pull_low, 1'b1);
    wait_cycle(f + 10);
    other_pull = 1'b0;
    bus.enable = 1'b0;
    wait_neg(f + 18);
    check_output("mm_idle_busy", bus.busy, 1'b0);

    // Asynchronous reset in the middle of LOW releases SCL at once.
    wait_cycle(cyc + 2);
    $display("[TB] async reset run");
    f = cyc + 1;
    apply_stimulus(4, 4, 1'b1);
    expect_tick(0, f);
    wait_cycle(f + 1);
    reset_n = 1'b0;
    #1;
    check_output("arst_pull", bus.scl_pull_low, 1'b0);
    check_output("arst_busy", bus.busy, 1'b0);
    bus.enable = 1'b0;
    wait_cycle(f + 3);
    reset_n = 1'b1;
    wait_neg(f + 6);
    check_output("arst_after_busy", bus.busy, 1'b0);

`ifdef I2C_SCL_TIMEOUT_EN
    // Stuck-low SCL: HIGH_WAIT times out after LIMIT cycles.
    wait_cycle(cyc + 2);
    $display("[TB] timeout run limit=%0d", LIMIT);
    f = cyc + 1;
    slave_hold = 1'b1;
    apply_stimulus(4, 4, 1'b1);
    expect_tick(0, f);
    expect_tick(1, f + 2);
    wait_neg(f + 19);
    check_output("to_before_busy", bus.busy, 1'b1);
    check_output("to_before_flag", bus.stretch_timeout, 1'b0);
    wait_neg(f + 20);
    check_output("to_flag", bus.stretch_timeout, 1'b1);
    check_output("to_busy", bus.busy, 1'b0);
    check_output("to_pull", bus.scl_pull_low, 1'b0);
    wait_neg(f + 25);
    check_output("to_no_restart", bus.busy, 1'b0);
    wait_cycle(f + 26);
    bus.enable = 1'b0;
    wait_neg(f + 27);
    check_output("to_cleared", bus.stretch_timeout, 1'b0);
    slave_hold = 1'b0;
`else
    check_output("no_timeout_flag", bus.stretch_timeout, 1'b0);
`endif

    wait_neg(cyc + 3);
    check_count("scoreboard_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
